// File: rtl/mod107_residue_accumulator_if.sv
// ============================================================================
// Module : mod107_residue_accumulator_if
// Brief  : Term-in / residue-out handshake bundle for the mod-107 accumulator
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mod107_residue_accumulator_if #(
   parameter int RES_W = 7
);
   logic             s_valid;
   logic             s_ready;
   logic [RES_W-1:0] s_term;
   logic             m_valid;
   logic             m_ready;
   logic [RES_W-1:0] m_residue;
   logic             m_err;

   modport master (
      output s_valid, s_term, m_ready,
      input  s_ready, m_valid, m_residue, m_err
   );

   modport slave (
      input  s_valid, s_term, m_ready,
      output s_ready, m_valid, m_residue, m_err
   );
endinterface

`default_nettype wire

// File: rtl/mod107_residue_accumulator.sv
// ============================================================================
// Module : mod107_residue_accumulator
// Brief  : Sums NUM_TERMS partial residues modulo MODULUS per operand frame
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mod107_residue_accumulator #(
   parameter int MODULUS   = 107,
   parameter int RES_W     = 7,
   parameter int NUM_TERMS = 50,
   parameter int CNT_W     = 6
) (
   input  wire logic clk,
   input  wire logic rst_n,
   mod107_residue_accumulator_if.slave bus,
   output logic      o_busy
);

   localparam logic [RES_W-1:0] c_MOD      = RES_W'(MODULUS);
   localparam logic [RES_W:0]   c_MOD_W    = (RES_W+1)'(MODULUS);
   localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(NUM_TERMS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [RES_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic             r_s_ready;
   logic             r_m_valid;
   logic [RES_W-1:0] r_m_residue;
   logic             r_m_err;
   logic             r_busy;

   logic             w_fire;
   logic             w_oor;
   logic [RES_W-1:0] w_term;
   logic [RES_W:0]   w_sum;
   logic [RES_W:0]   w_sum_red;
   logic [RES_W-1:0] w_acc_next;
   logic             w_err_next;
   logic             w_last;

   assign w_fire     = bus.s_valid && r_s_ready;
   assign w_oor      = (bus.s_term >= c_MOD);
   assign w_term     = w_oor ? (bus.s_term - c_MOD) : bus.s_term;
   // acc and term are both below MODULUS, so one conditional subtract reduces the sum
   assign w_sum      = {1'b0, r_acc} + {1'b0, w_term};
   assign w_sum_red  = (w_sum >= c_MOD_W) ? (w_sum - c_MOD_W) : w_sum;
   assign w_acc_next = w_sum_red[RES_W-1:0];
   assign w_err_next = r_err | w_oor;
   assign w_last     = (r_cnt == c_LAST_CNT);

   // acc, cnt and err are zero in IDLE, so the first term shares the ACCUM datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_s_ready   <= 1'b1;
         r_m_valid   <= 1'b0;
         r_m_residue <= '0;
         r_m_err     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_ACCUM: begin
               if (w_fire) begin
                  r_acc <= w_acc_next;
                  r_cnt <= r_cnt + 1'b1;
                  r_err <= w_err_next;
                  if (w_last) begin
                     r_state     <= S_DONE;
                     r_s_ready   <= 1'b0;
                     r_m_valid   <= 1'b1;
                     r_m_residue <= w_acc_next;
                     r_m_err     <= w_err_next;
                     r_busy      <= 1'b0;
                  end else begin
                     r_state <= S_ACCUM;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (bus.m_ready) begin
                  r_state   <= S_IDLE;
                  r_acc     <= '0;
                  r_cnt     <= '0;
                  r_err     <= 1'b0;
                  r_s_ready <= 1'b1;
                  r_m_valid <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_acc     <= '0;
               r_cnt     <= '0;
               r_err     <= 1'b0;
               r_s_ready <= 1'b1;
               r_m_valid <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.s_ready   = r_s_ready;
   assign bus.m_valid   = r_m_valid;
   assign bus.m_residue = r_m_residue;
   assign bus.m_err     = r_m_err;
   assign o_busy        = r_busy;

endmodule

`default_nettype wire
